// File: rtl/paddle_ctl.sv
// rtl/paddle_ctl.sv - two-player paddle position controller with debounce, acceleration and LFSR
module paddle_ctl #(
  parameter int SCREEN_H        = 600,
  parameter int PADDLE_HEIGHT   = 100,
  parameter int Y_INIT          = 250,
  parameter int STEP            = 2,
  parameter int STEP_DIV        = 400000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACCEL_TICKS     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn1_up,
  input  logic        btn1_dn,
  input  logic        btn2_up,
  input  logic        btn2_dn,
  input  logic        recentre,
  output logic [10:0] rect_y_pos,
  output logic [10:0] rect2_y_pos,
  output logic [3:0]  random_4
);

  localparam int Y_MAX = SCREEN_H - PADDLE_HEIGHT;
  localparam int DW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW    = $clog2(STEP_DIV + 1);

  typedef enum logic [1:0] {IDLE, SLOW, FAST} state_t;

  // Button bit order: [0]=p1 up, [1]=p1 down, [2]=p2 up, [3]=p2 down
  logic [3:0]    raw;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    deb;
  logic [DW-1:0] deb_cnt [4];

  logic [TW-1:0] tick_cnt;
  logic          tick;

  state_t             state    [2];
  state_t             state_nx [2];
  logic [1:0]         dir;
  logic [1:0]         dir_nx;
  logic [1:0][4:0]    run;
  logic [1:0][4:0]    run_nx;
  logic [1:0][10:0]   pos;
  logic [1:0][10:0]   pos_nx;

  logic [7:0] lfsr;

  assign raw = {btn2_dn, btn2_up, btn1_dn, btn1_up};

  // Move y by step in the given direction, clamped to [0, Y_MAX]
  function automatic logic [10:0] move_y(input logic [10:0] y, input logic down,
                                         input logic [11:0] step);
    logic [11:0] y12;
    logic [11:0] t;
    y12 = {1'b0, y};
    if (down) begin
      t = y12 + step;
      if (t > 12'(Y_MAX)) t = 12'(Y_MAX);
    end else begin
      if (y12 < step) t = 12'd0;
      else            t = y12 - step;
    end
    return t[10:0];
  endfunction

  // Two-flop synchroniser for the raw asynchronous buttons
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce: accept a new level only after DEBOUNCE_CYCLES unbroken cycles of disagreement
  always_ff @(posedge clk) begin
    if (rst) begin
      deb <= '0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Shared movement tick divider
  always_ff @(posedge clk) begin
    if (rst) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + 1'b1;
  end

  assign tick = (tick_cnt == TW'(STEP_DIV - 1));

  // Per-player movement FSM state, direction, run count and position registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        state[p] <= IDLE;
        run[p]   <= '0;
        pos[p]   <= 11'(Y_INIT);
      end
      dir <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        state[p] <= state_nx[p];
        run[p]   <= run_nx[p];
        pos[p]   <= pos_nx[p];
      end
      dir <= dir_nx;
    end
  end

  // Next-state logic: recentre wins over tick; moves are evaluated only on tick
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      state_nx[p] = state[p];
      dir_nx[p]   = dir[p];
      run_nx[p]   = run[p];
      pos_nx[p]   = pos[p];
      if (recentre) begin
        state_nx[p] = IDLE;
        run_nx[p]   = '0;
        pos_nx[p]   = 11'(Y_INIT);
      end else if (tick) begin
        if (deb[2*p] == deb[2*p+1]) begin
          state_nx[p] = IDLE;
          run_nx[p]   = '0;
        end else if (state[p] == IDLE || deb[2*p+1] != dir[p]) begin
          state_nx[p] = SLOW;
          dir_nx[p]   = deb[2*p+1];
          run_nx[p]   = 5'd1;
          pos_nx[p]   = move_y(pos[p], deb[2*p+1], 12'(STEP));
        end else if (state[p] == SLOW) begin
          run_nx[p] = run[p] + 5'd1;
          pos_nx[p] = move_y(pos[p], dir[p], 12'(STEP));
          if (run[p] + 5'd1 == 5'(ACCEL_TICKS)) state_nx[p] = FAST;
        end else begin
          pos_nx[p] = move_y(pos[p], dir[p], 12'(2 * STEP));
        end
      end
    end
  end

  // Free-running 8-bit Fibonacci LFSR
  always_ff @(posedge clk) begin
    if (rst) lfsr <= 8'hA5;
    else lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign rect_y_pos  = pos[0];
  assign rect2_y_pos = pos[1];
  assign random_4    = lfsr[3:0];

endmodule

// File: tb/tb_paddle_ctl.sv
// tb/tb_paddle_ctl.sv - directed self-checking bench for paddle_ctl
module tb_paddle_ctl;

  localparam int STEP_DIV = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn1_up, btn1_dn, btn2_up, btn2_dn;
  logic        recentre;
  logic [10:0] rect_y_pos, rect2_y_pos;
  logic [3:0]  random_4;

  int checks = 0;
  int errors = 0;
  int ph = 0;
  bit last_tick = 1'b0;

  paddle_ctl #(
    .SCREEN_H(600), .PADDLE_HEIGHT(100), .Y_INIT(250), .STEP(2),
    .STEP_DIV(STEP_DIV), .DEBOUNCE_CYCLES(4), .ACCEL_TICKS(4)
  ) dut (
    .clk(clk), .rst(rst),
    .btn1_up(btn1_up), .btn1_dn(btn1_dn), .btn2_up(btn2_up), .btn2_dn(btn2_dn),
    .recentre(recentre),
    .rect_y_pos(rect_y_pos), .rect2_y_pos(rect2_y_pos), .random_4(random_4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge; ph mirrors the divider value so the bench knows where ticks fall
  task automatic cyc();
    @(posedge clk);
    #1;
    last_tick = (ph == STEP_DIV - 1);
    ph = (ph + 1) % STEP_DIV;
  endtask

  task automatic to_tick();
    int n;
    n = 0;
    last_tick = 1'b0;
    while (!last_tick && n < STEP_DIV) begin
      cyc();
      n++;
    end
  endtask

  initial begin
    int exp_p;
    rst = 1'b1;
    btn1_up = 0; btn1_dn = 0; btn2_up = 0; btn2_dn = 0;
    recentre = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    ph = 0;

    check("reset_p1", rect_y_pos, 250);
    check("reset_p2", rect2_y_pos, 250);
    check("rand0", random_4, 4'h5);
    cyc();
    check("rand1", random_4, 4'hA);
    cyc();
    check("rand2", random_4, 4'h5);

    // Short glitch must never be accepted
    btn1_up = 1; cyc(); cyc(); btn1_up = 0;
    for (int i = 0; i < 5; i++) begin
      to_tick();
      check("glitch_p1", rect_y_pos, 250);
    end

    // Held up: four slow steps, then fast
    btn1_up = 1;
    to_tick(); check("up_slow1", rect_y_pos, 248);
    to_tick(); check("up_slow2", rect_y_pos, 246);
    to_tick(); check("up_slow3", rect_y_pos, 244);
    to_tick(); check("up_slow4", rect_y_pos, 242);
    to_tick(); check("up_fast1", rect_y_pos, 238);
    to_tick(); check("up_fast2", rect_y_pos, 234);
    btn1_up = 0;
    to_tick(); check("release1", rect_y_pos, 234);
    to_tick(); check("release2", rect_y_pos, 234);

    // Drive player 2 down to 490 (4 slow + 58 fast ticks)
    btn2_dn = 1;
    for (int i = 0; i < 62; i++) to_tick();
    check("p2_at_490", rect2_y_pos, 490);
    check("p1_indep", rect_y_pos, 234);
    btn2_dn = 0;
    to_tick(); check("p2_idle_490", rect2_y_pos, 490);

    // From 490: slow to 498, then clamp at 500
    btn2_dn = 1;
    exp_p = 490;
    for (int i = 0; i < 4; i++) begin
      exp_p += 2;
      to_tick(); check("p2_dn_slow", rect2_y_pos, exp_p);
    end
    for (int i = 0; i < 3; i++) begin
      to_tick(); check("p2_clamp", rect2_y_pos, 500);
    end
    btn2_dn = 0; btn2_up = 1;
    to_tick(); check("p2_reverse", rect2_y_pos, 498);
    btn2_up = 0;
    to_tick(); check("p2_stop", rect2_y_pos, 498);

    // Both directions on player 1 cancel out
    btn1_up = 1; btn1_dn = 1;
    to_tick(); check("both_1", rect_y_pos, 234);
    to_tick(); check("both_2", rect_y_pos, 234);
    btn1_dn = 0;
    to_tick(); check("both_rel1", rect_y_pos, 232);
    to_tick(); check("both_rel2", rect_y_pos, 230);

    // Recentre coinciding with a tick while player 1 moves
    while (ph != STEP_DIV - 1) cyc();
    recentre = 1;
    cyc();
    recentre = 0;
    check("recentre_p1", rect_y_pos, 250);
    check("recentre_p2", rect2_y_pos, 250);
    to_tick();
    check("post_rc_p1", rect_y_pos, 248);
    check("post_rc_p2", rect2_y_pos, 250);

    // Reset in the middle of a move
    cyc(); cyc();
    rst = 1;
    cyc();
    check("midrst_p1", rect_y_pos, 250);
    check("midrst_rand", random_4, 4'h5);
    rst = 0;
    ph = 0;
    btn1_up = 0;
    cyc();
    check("midrst_rand1", random_4, 4'hA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
